// File: rtl/tbird_taillight_fsm_pkg.sv
// Shared definitions for the tail-light sequencer: state encodings and widths.
package tbird_taillight_fsm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_LEFT    = 3'd1;
    localparam logic [STATE_W-1:0] ST_RIGHT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_HAZ_ON  = 3'd3;
    localparam logic [STATE_W-1:0] ST_HAZ_OFF = 3'd4;

    // Bit positions of the buttons inside the synchronised request vector.
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_HAZARD = 2;
    localparam int BTN_W      = 3;

endpackage

// File: rtl/tbird_taillight_fsm_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; reusable for any width.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tbird_taillight_fsm.sv
// Thunderbird tail-light sequencer: steps one light pattern per clock_en tick.
module tbird_taillight_fsm
    import tbird_taillight_fsm_pkg::*;
#(
    parameter int N_LAMPS = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clock_en,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
    output logic [N_LAMPS-1:0] left_lamps,
    output logic [N_LAMPS-1:0] right_lamps,
    output logic               busy,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int STEP_W = $clog2(N_LAMPS + 1);
    localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(N_LAMPS);

    logic [BTN_W-1:0]   btn_sync;
    logic [STATE_W-1:0] state, state_next;
    logic [STEP_W-1:0]  step, step_next;
    logic               req_left, req_right, req_hazard;

    sync_2ff #(.WIDTH(BTN_W)) u_btn_sync (
        .clock (clock),
        .reset (reset),
        .d     ({hazard, right, left}),
        .q     (btn_sync)
    );

    assign req_left   = btn_sync[BTN_LEFT];
    assign req_right  = btn_sync[BTN_RIGHT];
    assign req_hazard = btn_sync[BTN_HAZARD];

    function automatic logic [N_LAMPS-1:0] thermometer(input logic [STEP_W-1:0] k);
        logic [N_LAMPS-1:0] t;
        for (int i = 0; i < N_LAMPS; i++) begin
            t[i] = (i < int'(k));
        end
        return t;
    endfunction

    always_comb begin
        state_next = ST_IDLE;
        step_next  = '0;
        case (state)
            ST_IDLE, ST_HAZ_OFF: begin
                if (req_hazard || (req_left && req_right)) begin
                    state_next = ST_HAZ_ON;
                end else if (req_left) begin
                    state_next = ST_LEFT;
                    step_next  = STEP_W'(1);
                end else if (req_right) begin
                    state_next = ST_RIGHT;
                    step_next  = STEP_W'(1);
                end
            end
            // A running sequence ignores direction changes; only hazard cuts it short.
            ST_LEFT, ST_RIGHT: begin
                if (req_hazard) begin
                    state_next = ST_HAZ_ON;
                end else if (step != STEP_MAX) begin
                    state_next = state;
                    step_next  = step + STEP_W'(1);
                end
            end
            ST_HAZ_ON: state_next = ST_HAZ_OFF;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            step  <= '0;
        end else if (clock_en) begin
            state <= state_next;
            step  <= step_next;
        end
    end

    // Lamps decode the next state so the pattern appears right after the tick edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            left_lamps  <= '0;
            right_lamps <= '0;
        end else if (clock_en) begin
            case (state_next)
                ST_LEFT: begin
                    left_lamps  <= thermometer(step_next);
                    right_lamps <= '0;
                end
                ST_RIGHT: begin
                    left_lamps  <= '0;
                    right_lamps <= thermometer(step_next);
                end
                ST_HAZ_ON: begin
                    left_lamps  <= '1;
                    right_lamps <= '1;
                end
                default: begin
                    left_lamps  <= '0;
                    right_lamps <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_tbird_taillight_fsm.sv
// Directed bench for the tail-light sequencer (N_LAMPS=3, one tick every 32 clocks).
module tb_tbird_taillight_fsm;

    logic       clock    = 1'b0;
    logic       reset    = 1'b0;
    logic       clock_en = 1'b0;
    logic       left     = 1'b0;
    logic       right    = 1'b0;
    logic       hazard   = 1'b0;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;
    logic       busy;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tbird_taillight_fsm #(.N_LAMPS(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .clock_en    (clock_en),
        .left        (left),
        .right       (right),
        .hazard      (hazard),
        .left_lamps  (left_lamps),
        .right_lamps (right_lamps),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lamps(input string tag, input logic [2:0] l_exp, input logic [2:0] r_exp,
                         input logic b_exp);
        check({tag, "_left"},  {5'd0, left_lamps},  {5'd0, l_exp});
        check({tag, "_right"}, {5'd0, right_lamps}, {5'd0, r_exp});
        check({tag, "_busy"},  {7'd0, busy},        {7'd0, b_exp});
    endtask

    // Called at a negedge; pulses clock_en across exactly one rising edge and
    // returns at the negedge following that tick edge.
    task automatic tick(input int idle_clks = 31);
        repeat (idle_clks) @(negedge clock);
        clock_en = 1'b1;
        @(negedge clock);
        clock_en = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clock);
        lamps("por", 3'b000, 3'b000, 1'b0);
        check("por_state", {5'd0, state_dbg}, 8'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Left held for five ticks, then released mid-sequence
        left = 1'b1;
        tick(); lamps("l_t1", 3'b001, 3'b000, 1'b1);
        check("l_t1_state", {5'd0, state_dbg}, 8'd1);
        tick(); lamps("l_t2", 3'b011, 3'b000, 1'b1);
        tick(); lamps("l_t3", 3'b111, 3'b000, 1'b1);
        tick(); lamps("l_t4", 3'b000, 3'b000, 1'b0);
        tick(); lamps("l_t5", 3'b001, 3'b000, 1'b1);
        left = 1'b0;
        tick(); lamps("l_t6", 3'b011, 3'b000, 1'b1);
        tick(); lamps("l_t7", 3'b111, 3'b000, 1'b1);
        tick(); lamps("l_t8", 3'b000, 3'b000, 1'b0);

        // Right for one tick; opposite direction pressed mid-sequence is ignored
        right = 1'b1;
        tick(); lamps("r_t1", 3'b000, 3'b001, 1'b1);
        check("r_t1_state", {5'd0, state_dbg}, 8'd2);
        right = 1'b0;
        left  = 1'b1;
        tick(); lamps("r_t2", 3'b000, 3'b011, 1'b1);
        tick(); lamps("r_t3", 3'b000, 3'b111, 1'b1);
        left = 1'b0;
        tick(); lamps("r_t4", 3'b000, 3'b000, 1'b0);
        tick(); lamps("r_t5", 3'b000, 3'b000, 1'b0);

        // Hazard aborts LEFT at step 2, blinks while held, release in HAZ_ON
        left = 1'b1;
        tick(); lamps("h_t1", 3'b001, 3'b000, 1'b1);
        tick(); lamps("h_t2", 3'b011, 3'b000, 1'b1);
        left   = 1'b0;
        hazard = 1'b1;
        tick(); lamps("h_t3", 3'b111, 3'b111, 1'b1);
        check("h_t3_state", {5'd0, state_dbg}, 8'd3);
        tick(); lamps("h_t4", 3'b000, 3'b000, 1'b1);
        check("h_t4_state", {5'd0, state_dbg}, 8'd4);
        tick(); lamps("h_t5", 3'b111, 3'b111, 1'b1);
        hazard = 1'b0;
        tick(); lamps("h_t6", 3'b000, 3'b000, 1'b1);
        tick(); lamps("h_t7", 3'b000, 3'b000, 1'b0);

        // Left and right together from IDLE behave as hazard
        left  = 1'b1;
        right = 1'b1;
        tick(); lamps("lr_t1", 3'b111, 3'b111, 1'b1);
        left  = 1'b0;
        right = 1'b0;
        tick(); lamps("lr_t2", 3'b000, 3'b000, 1'b1);
        tick(); lamps("lr_t3", 3'b000, 3'b000, 1'b0);

        // Request held two clocks before the tick is not seen
        left = 1'b1;
        tick(1);
        left = 1'b0;
        lamps("s2_t1", 3'b000, 3'b000, 1'b0);
        tick(); lamps("s2_t2", 3'b000, 3'b000, 1'b0);

        // Held three clocks before the tick is honoured
        left = 1'b1;
        tick(2);
        lamps("s3_t1", 3'b001, 3'b000, 1'b1);

        // Toggling left with clock_en low changes nothing
        for (int i = 0; i < 6; i++) begin
            left = ~left;
            @(negedge clock);
            lamps("hold", 3'b001, 3'b000, 1'b1);
        end
        left = 1'b0;
        tick(); lamps("s3_t2", 3'b011, 3'b000, 1'b1);
        tick(); lamps("s3_t3", 3'b111, 3'b000, 1'b1);
        tick(); lamps("s3_t4", 3'b000, 3'b000, 1'b0);

        // clock_en held high: one step per clock
        left = 1'b1;
        repeat (3) @(negedge clock);
        clock_en = 1'b1;
        @(negedge clock); lamps("ce_1", 3'b001, 3'b000, 1'b1);
        @(negedge clock); lamps("ce_2", 3'b011, 3'b000, 1'b1);
        @(negedge clock); lamps("ce_3", 3'b111, 3'b000, 1'b1);
        @(negedge clock); lamps("ce_4", 3'b000, 3'b000, 1'b0);
        @(negedge clock); lamps("ce_5", 3'b001, 3'b000, 1'b1);
        left = 1'b0;
        @(negedge clock); lamps("ce_6", 3'b011, 3'b000, 1'b1);
        @(negedge clock); lamps("ce_7", 3'b111, 3'b000, 1'b1);
        @(negedge clock); lamps("ce_8", 3'b000, 3'b000, 1'b0);
        @(negedge clock); lamps("ce_9", 3'b000, 3'b000, 1'b0);
        clock_en = 1'b0;

        // Asynchronous reset while lamps are lit clears them without a clock edge
        hazard = 1'b1;
        repeat (3) @(negedge clock);
        tick(); lamps("ar_lit", 3'b111, 3'b111, 1'b1);
        #2 reset = 1'b0;
        #1 lamps("ar_clr", 3'b000, 3'b000, 1'b0);
        check("ar_state", {5'd0, state_dbg}, 8'd0);
        hazard = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick(); lamps("ar_after", 3'b000, 3'b000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
